adder_share_ctrl: RTL and testbench
===================================

# adder_share_ctrl

Sequencer and round-robin arbiter that shares one `RCA_32_bit` ripple-carry adder instance among NREQ requesters. It supports single-pass 32-bit adds and two-pass 64-bit adds, chaining the carry through a register between passes. It sits between the ALU-side requesters and the adder, giving a registered result with a valid/ready response handshake.

## Interface
- NREQ, 2, number of requesters; legal values 2..8.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted; one-hot or zero.
- req_wide  in  NREQ  per requester: 1 = 64-bit add, 0 = 32-bit add.
- req_a  in  64*NREQ  operand A; requester i owns bits [64i+63:64i].
- req_b  in  64*NREQ  operand B; same packing as req_a.
- req_cin  in  NREQ  carry-in per requester.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns the result.
- rsp_sum  out  64  sum; [63:32] is zero for narrow adds.
- rsp_cout  out  1  carry out of the final pass.

## Operation
- The FSM has four states: IDLE, LO, HI, DONE.
- IDLE:
  - The arbiter picks grant g, the first requester with req_valid set, searching from pointer ptr and wrapping at NREQ-1 -> 0.
  - req_ready[g] = 1, combinationally, only in IDLE and only while rst = 0.
  - On handshake, capture a, b, cin, wide and g into internal registers, then go to LO.
  - With no valid request, stay in IDLE.
- LO:
  - The adder takes a[31:0], b[31:0] and cin.
  - Register the sum into sum[31:0] and the adder carry-out into carry_q.
  - Go to HI if wide = 1, otherwise DONE.
  - On the narrow path, sum[63:32] = 0 and rsp_cout = carry_q.
- HI:
  - The adder takes a[63:32], b[63:32] and carry_q.
  - Register the sum into sum[63:32] and the carry-out into rsp_cout.
  - Go to DONE.
- DONE:
  - rsp_valid = 1; rsp_id, rsp_sum and rsp_cout hold stable.
  - On rsp_ready = 1: go to IDLE and set ptr = (g+1) mod NREQ.
- Only one transaction is in flight. No request is accepted outside IDLE.
- Arithmetic is unsigned modulo 2^32 (narrow) or 2^64 (wide). Carry-out is the true carry of the full-width add.
- Requesters must hold their operands stable only until their handshake.

## Timing
- Latency: handshake in cycle N gives rsp_valid in cycle N+2 (narrow) or N+3 (wide).
- Minimum issue interval: 3 cycles narrow, 4 cycles wide, when rsp_ready is held high. DONE -> IDLE costs one cycle.
- Simultaneous requests: requester ptr wins, else the next valid index upward with wrap. Losers see req_ready = 0 and must keep req_valid asserted.
- rsp_ready high at the cycle DONE is entered: complete that same cycle, so rsp_valid is high for exactly one cycle.
- rsp_ready low: hold DONE indefinitely with all rsp_* outputs stable.
- A new req_valid during LO, HI or DONE is ignored; req_ready stays 0.
- Reset values: state = IDLE, ptr = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, carry_q = 0, req_ready = 0.
- Reset mid-operation drops the in-flight transaction. No response is issued for it.

## Configuration
- Macro: `ADDER_SHARE_OVF_EN`.
- Defined:
  - Adds output rsp_ovf (1 bit) = signed overflow of the final pass: (a_msb == b_msb) && (sum_msb != a_msb).
  - The MSB is bit 31 for narrow adds and bit 63 for wide adds.
  - rsp_ovf is registered with the other rsp_* fields, resets to 0 and is valid with rsp_valid.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package adder_share_pkg contains:
  - state enum st_e {ST_IDLE, ST_LO, ST_HI, ST_DONE};
  - WORD_W = 32 and DWORD_W = 64;
  - MAX_NREQ = 8.
- One `RCA_32_bit` instance, with operand muxes driven by the state.
- Sub-module rr_arbiter, parameterised by NREQ: inputs req vector, ptr and en; outputs one-hot grant and encoded index.

## Test plan
- Single narrow add:
  - Stimulus: requester 0 sends a = 0xFFFFFFFF, b = 0x1, cin = 0, wide = 0.
  - Response: 2 cycles after the handshake, rsp_sum = 0x0, rsp_cout = 1, rsp_id = 0.
- Wide add with carry across the word boundary:
  - Stimulus: a = 0x00000000_FFFFFFFF, b = 0x1, cin = 0.
  - Response: 3 cycles after the handshake, rsp_sum = 0x00000001_00000000, rsp_cout = 0.
- Wide add overflowing 64 bits:
  - Stimulus: a = b = 0x80000000_00000000, cin = 1.
  - Response: rsp_sum = 0x1, rsp_cout = 1; rsp_ovf = 1 with `ADDER_SHARE_OVF_EN` defined.
- Fairness:
  - Stimulus: NREQ = 3, all requesters valid continuously.
  - Response: grants in the order 0, 1, 2, 0, 1 with matching rsp_id.
- Response backpressure:
  - Stimulus: hold rsp_ready = 0 for 5 cycles in DONE.
  - Response: rsp_* outputs stable, all req_ready = 0, completion in the cycle rsp_ready rises.
- Reset mid-operation:
  - Stimulus: assert rst during HI.
  - Response: next cycle all outputs are at reset values and no rsp_valid is seen for the dropped request. A fresh request then completes correctly with requester 0 favoured.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing controller: FSM state encoding,
// datapath word widths and the upper bound on the requester count.
package adder_share_pkg;

  localparam int WORD_W   = 32;
  localparam int DWORD_W  = 64;
  localparam int MAX_NREQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } st_e;

endpackage

// File: rtl/RCA_32_bit.sv
// 32-bit ripple-carry adder: a chain of full adders from bit 0 to bit 31.
module RCA_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[32];

endmodule

// File: rtl/adder_share_ctrl_arb.sv
// Round-robin arbiter: grants the first set request found when searching
// upward from ptr, wrapping from NREQ-1 back to 0. en gates the grant vector;
// idx always reports the winning index.
module rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  // Rotating priority search starting at ptr.
  always_comb begin
    logic [IDX_W:0] pos;
    logic           found;
    // NOTE: every variable gets a default before the loop so no path leaves one unassigned and infers a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int off = 0; off < NREQ; off++) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(off);
      if (pos >= (IDX_W + 1)'(NREQ)) begin
        pos = pos - (IDX_W + 1)'(NREQ);
      end
      if (!found && req[pos[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[pos[IDX_W-1:0]]   = en;
        idx                     = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one 32-bit ripple-carry adder among NREQ requesters. Narrow adds take
// one adder pass, wide adds take two with the carry chained through carry_q.
// Optional feature macro: ADDER_SHARE_OVF_EN adds the signed-overflow output rsp_ovf.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_wide,
  input  logic [DWORD_W*NREQ-1:0] req_a,
  input  logic [DWORD_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDX_W-1:0]        rsp_id,
  output logic [DWORD_W-1:0]      rsp_sum,
  output logic                    rsp_cout
`ifdef ADDER_SHARE_OVF_EN
  ,
  output logic                    rsp_ovf
`endif
);

  st_e                state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gidx;
  logic [DWORD_W-1:0] a_q, b_q;
  logic               cin_q, wide_q;
  logic               carry_q;
  logic [DWORD_W-1:0] sel_a, sel_b;
  logic               sel_cin, sel_wide;
  logic [WORD_W-1:0]  add_a, add_b, add_sum;
  logic               add_cin, add_cout;
  logic               take;

  // Requests are only offered to the arbiter while idle and out of reset.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    ((state == ST_IDLE) && !rst),
    .grant (req_ready),
    .idx   (gidx)
  );

  assign take = (state == ST_IDLE) && (|req_valid);

  // Select the granted requester's operand slice.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_cin  = 1'b0;
    sel_wide = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IDX_W'(i)) begin
        sel_a    = req_a[DWORD_W*i +: DWORD_W];
        sel_b    = req_b[DWORD_W*i +: DWORD_W];
        sel_cin  = req_cin[i];
        sel_wide = req_wide[i];
      end
    end
  end

  // Capture the winning operands at the handshake.
  // NOTE: operand registers carry no reset; they are always written at the handshake before anything reads them.
  always_ff @(posedge clk) begin
    if (take) begin
      a_q    <= sel_a;
      b_q    <= sel_b;
      cin_q  <= sel_cin;
      wide_q <= sel_wide;
    end
  end

  // Feed the shared adder the low word in LO and the high word in HI.
  always_comb begin
    add_a   = a_q[WORD_W-1:0];
    add_b   = b_q[WORD_W-1:0];
    add_cin = cin_q;
    if (state == ST_HI) begin
      add_a   = a_q[DWORD_W-1:WORD_W];
      add_b   = b_q[DWORD_W-1:WORD_W];
      add_cin = carry_q;
    end
  end

  RCA_32_bit u_rca (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Sequencer: IDLE -> LO -> (HI) -> DONE, with registered response fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      rsp_id    <= '0;
      carry_q   <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_valid <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      // NOTE: every register here updates with <= so all reads see pre-edge values.
      case (state)
        ST_IDLE: begin
          if (take) begin
            rsp_id <= gidx;
            state  <= ST_LO;
          end
        end
        ST_LO: begin
          rsp_sum[WORD_W-1:0] <= add_sum;
          carry_q             <= add_cout;
          if (wide_q) begin
            state <= ST_HI;
          end else begin
            rsp_sum[DWORD_W-1:WORD_W] <= '0;
            rsp_cout                  <= add_cout;
`ifdef ADDER_SHARE_OVF_EN
            rsp_ovf <= (a_q[WORD_W-1] == b_q[WORD_W-1]) && (add_sum[WORD_W-1] != a_q[WORD_W-1]);
`endif
            rsp_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_HI: begin
          rsp_sum[DWORD_W-1:WORD_W] <= add_sum;
          rsp_cout                  <= add_cout;
`ifdef ADDER_SHARE_OVF_EN
          rsp_ovf <= (a_q[DWORD_W-1] == b_q[DWORD_W-1]) && (add_sum[WORD_W-1] != a_q[DWORD_W-1]);
`endif
          rsp_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (rsp_id == IDX_W'(NREQ - 1)) ? '0 : rsp_id + IDX_W'(1);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl with NREQ = 3: directed cases,
// fairness, backpressure, random traffic and reset mid-operation, checked
// against a plain-arithmetic reference model.
module tb_adder_share_ctrl;

  localparam int NREQ  = 3;
  localparam int IDX_W = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_wide;
  logic [64*NREQ-1:0]   req_a;
  logic [64*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDX_W-1:0]     rsp_id;
  logic [63:0]          rsp_sum;
  logic                 rsp_cout;
`ifdef ADDER_SHARE_OVF_EN
  logic                 rsp_ovf;
`endif

  always #5 clk = ~clk;

  adder_share_ctrl #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wide  (req_wide),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_SHARE_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [63:0] op_a [NREQ];
  logic [63:0] op_b [NREQ];
  logic        op_cin [NREQ];
  logic        op_wide [NREQ];
  int          m_ptr;
  logic [63:0] obs_sum;
  int          obs_id;
  logic        obs_cout;
  logic        obs_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_a[64*i +: 64] = op_a[i];
      req_b[64*i +: 64] = op_b[i];
      req_cin[i]        = op_cin[i];
      req_wide[i]       = op_wide[i];
    end
  endtask

  task automatic rand_op(input int i);
    op_a[i]    = {$urandom, $urandom};
    op_b[i]    = ($urandom_range(0, 3) == 0) ? ~op_a[i] : {$urandom, $urandom};
    op_cin[i]  = 1'($urandom_range(0, 1));
    op_wide[i] = 1'($urandom_range(0, 1));
  endtask

  // Requester that should win: first valid at or after p, wrapping.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int off = 0; off < NREQ; off++) begin
      if (v[(p + off) % NREQ]) return (p + off) % NREQ;
    end
    return -1;
  endfunction

  // Reference result {ovf, cout, sum[63:0]} from unsigned integer addition.
  function automatic logic [65:0] model(input int i);
    logic [64:0] full;
    logic [63:0] s;
    logic        co, ov;
    if (op_wide[i]) begin
      full = {1'b0, op_a[i]} + {1'b0, op_b[i]} + 65'(op_cin[i]);
      s    = full[63:0];
      co   = full[64];
      ov   = (op_a[i][63] == op_b[i][63]) && (s[63] != op_a[i][63]);
    end else begin
      full = {33'b0, op_a[i][31:0]} + {33'b0, op_b[i][31:0]} + 65'(op_cin[i]);
      s    = {32'b0, full[31:0]};
      co   = full[32];
      ov   = (op_a[i][31] == op_b[i][31]) && (s[31] != op_a[i][31]);
    end
    return {ov, co, s};
  endfunction

  // One transaction from the currently valid requesters. Entered at posedge+1
  // with inputs applied; returns at posedge+1 with the DUT back in IDLE.
  task automatic run_one(input int hold, input bit refill);
    int              g, lat, cyc;
    logic [65:0]     exp;
    logic [NREQ-1:0] exp_rdy;
    g = pick(req_valid, m_ptr);
    check("grant_exists", 64'(g >= 0), 64'd1);
    if (g < 0) return;
    exp     = model(g);
    lat     = op_wide[g] ? 3 : 2;
    exp_rdy = '0;
    exp_rdy[g] = 1'b1;
    rsp_ready = (hold == 0);
    #1;
    check("req_ready_grant", req_ready, exp_rdy);
    @(posedge clk); #1;
    if (refill) rand_op(g);
    else req_valid[g] = 1'b0;
    drive();
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 8) begin
      check("req_ready_busy", req_ready, '0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, lat);
    if (cyc >= 8) return;
    obs_sum  = rsp_sum;
    obs_id   = int'(rsp_id);
    obs_cout = rsp_cout;
    check("rsp_id", rsp_id, g);
    check("rsp_sum", rsp_sum, exp[63:0]);
    check("rsp_cout", rsp_cout, exp[64]);
`ifdef ADDER_SHARE_OVF_EN
    obs_ovf = rsp_ovf;
    check("rsp_ovf", rsp_ovf, exp[65]);
`else
    obs_ovf = exp[65];
`endif
    check("req_ready_done", req_ready, '0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_sum", rsp_sum, exp[63:0]);
      check("hold_id", rsp_id, g);
      check("hold_cout", rsp_cout, exp[64]);
      check("hold_ready", req_ready, '0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_valid_drop", rsp_valid, 1'b0);
    m_ptr = (g + 1) % NREQ;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with all requesters valid to confirm req_ready is gated.
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) rand_op(i);
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_id", rsp_id, '0);
    check("rst_sum", rsp_sum, '0);
    check("rst_cout", rsp_cout, 1'b0);
    check("rst_ready", req_ready, '0);
    rst       = 1'b0;
    req_valid = '0;
    m_ptr     = 0;
    @(posedge clk); #1;
    check("idle_valid", rsp_valid, 1'b0);

    // Narrow add wrapping at 32 bits.
    op_a[0] = 64'h0000_0000_FFFF_FFFF; op_b[0] = 64'h1; op_cin[0] = 1'b0; op_wide[0] = 1'b0;
    req_valid = 3'b001; drive();
    run_one(0, 1'b0);
    check("tp_narrow_sum", obs_sum, 64'h0);
    check("tp_narrow_cout", obs_cout, 1'b1);
    check("tp_narrow_id", obs_id, 0);

    // Wide add carrying across the word boundary.
    op_a[1] = 64'h0000_0000_FFFF_FFFF; op_b[1] = 64'h1; op_cin[1] = 1'b0; op_wide[1] = 1'b1;
    req_valid = 3'b010; drive();
    run_one(0, 1'b0);
    check("tp_wide_sum", obs_sum, 64'h0000_0001_0000_0000);
    check("tp_wide_cout", obs_cout, 1'b0);

    // Wide add overflowing 64 bits.
    op_a[2] = 64'h8000_0000_0000_0000; op_b[2] = 64'h8000_0000_0000_0000;
    op_cin[2] = 1'b1; op_wide[2] = 1'b1;
    req_valid = 3'b100; drive();
    run_one(0, 1'b0);
    check("tp_ovf64_sum", obs_sum, 64'h1);
    check("tp_ovf64_cout", obs_cout, 1'b1);
`ifdef ADDER_SHARE_OVF_EN
    check("tp_ovf64_ovf", obs_ovf, 1'b1);
`endif

    // Fairness: all requesters valid continuously.
    for (int i = 0; i < NREQ; i++) rand_op(i);
    req_valid = '1; drive();
    for (int i = 0; i < 5; i++) begin
      run_one(0, 1'b1);
      check("fair_order", obs_id, i % NREQ);
    end

    // Backpressure: rsp_ready low for five DONE cycles while others request.
    for (int i = 0; i < NREQ; i++) rand_op(i);
    req_valid = '1; drive();
    run_one(4, 1'b0);
    check("bp_id", obs_id, 2);
    req_valid = '0; drive();

    // Random traffic.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NREQ; i++) rand_op(i);
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      drive();
      run_one($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      req_valid = '0; drive();
    end

    // Reset during the HI pass of a wide add.
    rand_op(1); op_wide[1] = 1'b1;
    req_valid = 3'b010; drive();
    #1;
    check("mid_rst_grant", req_ready, 3'b010);
    @(posedge clk); #1;
    req_valid = '0; drive();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    req_valid = '1; drive();
    #1;
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_id", rsp_id, '0);
    check("mid_rst_sum", rsp_sum, '0);
    check("mid_rst_cout", rsp_cout, 1'b0);
    check("mid_rst_ready", req_ready, '0);
`ifdef ADDER_SHARE_OVF_EN
    check("mid_rst_ovf", rsp_ovf, 1'b0);
`endif
    rst = 1'b0;
    req_valid = '0; drive();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("dropped_no_rsp", rsp_valid, 1'b0);
    end
    m_ptr = 0;
    rand_op(0); rand_op(2);
    req_valid = 3'b101; drive();
    run_one(0, 1'b0);
    check("post_rst_id", obs_id, 0);
    req_valid = '0; drive();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
